// File: rtl/bus_hold_src.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bus_hold_src                                                |
// | Source-domain staging register that keeps o_data_a stable for at     |
// | least HOLD_CYCLES clocks, with a one-word pending buffer.            |
// | Option : BUS_HOLD_SRC_SKIP_SAME_EN drops words equal to next value.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module bus_hold_src #(
    parameter int                   BUS_WIDTH   = 1,
    parameter int                   HOLD_CYCLES = 8,
    parameter logic [BUS_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                 i_clk_a,
    input  logic                 i_rst_a,
    input  logic                 i_valid,
    input  logic [BUS_WIDTH-1:0] i_data,
    output logic                 o_ready,
    output logic [BUS_WIDTH-1:0] o_data_a,
    output logic                 o_update,
    output logic                 o_busy
);

    localparam int                 c_cnt_w   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic [BUS_WIDTH-1:0] pend_data_q, pend_data_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 update_q, update_d;

    logic   w_hold_done;
    logic   w_accept;
    logic   w_drop;
    state_t w_state;

    assign w_hold_done = (cnt_q == c_cnt_max);
    assign w_accept    = i_valid & ~pend_vld_q;

`ifdef BUS_HOLD_SRC_SKIP_SAME_EN
    // The "next value" is whatever o_data_a will eventually show.
    logic [BUS_WIDTH-1:0] w_next_val;
    assign w_next_val = pend_vld_q ? pend_data_q : data_q;
    assign w_drop     = (i_data == w_next_val);
`else
    assign w_drop     = 1'b0;
`endif

    always_comb begin
        w_state = ST_HOLD;
        if (pend_vld_q) begin
            w_state = ST_FULL;
        end else if (w_hold_done) begin
            w_state = ST_IDLE;
        end
    end

    always_comb begin
        data_d      = data_q;
        pend_data_d = pend_data_q;
        pend_vld_d  = pend_vld_q;
        update_d    = 1'b0;
        cnt_d       = w_hold_done ? cnt_q : cnt_q + c_cnt_w'(1);
        case (w_state)
            ST_FULL: begin
                if (w_hold_done) begin
                    data_d     = pend_data_q;
                    pend_vld_d = 1'b0;
                    cnt_d      = '0;
                    update_d   = 1'b1;
                end
            end
            ST_IDLE: begin
                if (w_accept && !w_drop) begin
                    data_d   = i_data;
                    cnt_d    = '0;
                    update_d = 1'b1;
                end
            end
            ST_HOLD: begin
                // Hold counter keeps running; the word waits in pending.
                if (w_accept && !w_drop) begin
                    pend_data_d = i_data;
                    pend_vld_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk_a or posedge i_rst_a) begin
        if (i_rst_a) begin
            data_q      <= RESET_VAL;
            pend_data_q <= '0;
            pend_vld_q  <= 1'b0;
            cnt_q       <= c_cnt_max;
            update_q    <= 1'b0;
        end else begin
            data_q      <= data_d;
            pend_data_q <= pend_data_d;
            pend_vld_q  <= pend_vld_d;
            cnt_q       <= cnt_d;
            update_q    <= update_d;
        end
    end

    assign o_data_a = data_q;
    assign o_update = update_q;
    assign o_ready  = ~pend_vld_q;
    assign o_busy   = ~w_hold_done | pend_vld_q;

endmodule
`default_nettype wire
